// File: rtl/ov7670_capture.sv
// rtl/ov7670_capture.sv - OV7670 RGB565 capture, 8x decimation, RGB444 frame buffer writer
//
// Ports:
//   clk, reset              system clock (only clock), synchronous active-high reset
//   cam_pclk/vsync/href/d   raw asynchronous camera bus, oversampled here
//   capture_en              1 = keep capturing frames, 0 = stop after the current frame
//   wr_en/wr_addr/wr_data   frame buffer write port, one strobe per kept pixel
//   frame_done              one-cycle pulse at the end of a captured frame
//   busy                    high while a frame is being captured

module ov7670_capture #(
    parameter int c_img_cols    = 80,
    parameter int c_img_rows    = 60,
    parameter int c_nb_img_pxls = 13,
    parameter int c_decim_log2  = 3,
    parameter int c_nb_buf      = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cam_pclk,
    input  logic                     cam_vsync,
    input  logic                     cam_href,
    input  logic [7:0]               cam_d,
    input  logic                     capture_en,
    output logic                     wr_en,
    output logic [c_nb_img_pxls-1:0] wr_addr,
    output logic [c_nb_buf-1:0]      wr_data,
    output logic                     frame_done,
    output logic                     busy
);

    localparam logic [c_nb_img_pxls-1:0] c_last_addr = c_nb_img_pxls'(c_img_cols * c_img_rows - 1);
    localparam logic [9:0]               c_col_lim   = 10'(c_img_cols);
    localparam logic [8:0]               c_row_lim   = 9'(c_img_rows);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_VS,
        WAIT_ACT,
        ACTIVE
    } state_t;

    state_t state, state_nxt;

    // Control sync stages pack {vsync, href, pclk}; s3 exists only for edge detection.
    logic [2:0] ctl_s1, ctl_s2, ctl_s3;
    logic [7:0] d_s1, d_s2;

    logic vsync_s2, href_s2, pclk_rise, href_fall, vsync_rise;

    logic       phase;
    logic [6:0] byte0;          // {R[4:1], G[5:3]} of the first byte; R[0] is never used
    logic [9:0] src_col;
    logic [8:0] src_row;
    logic       pix_pend;
    logic [c_nb_buf-1:0] pix_data;
    logic       done_pend;
    logic       clr_frame, end_frame;
    logic       keep_pixel;

    assign vsync_s2   = ctl_s2[2];
    assign href_s2    = ctl_s2[1];
    assign pclk_rise  = ctl_s2[0] & ~ctl_s3[0];
    assign href_fall  = ctl_s3[1] & ~ctl_s2[1];
    assign vsync_rise = ctl_s2[2] & ~ctl_s3[2];

    // Keep only the top-left source pixel of each 8x8 block that lands inside the buffer.
    assign keep_pixel = (src_col[c_decim_log2-1:0] == '0) && (src_row[c_decim_log2-1:0] == '0) &&
                        ((src_col >> c_decim_log2) < c_col_lim) &&
                        ((src_row >> c_decim_log2) < c_row_lim);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        clr_frame = 1'b0;
        end_frame = 1'b0;
        unique case (state)
            IDLE: begin
                if (capture_en) state_nxt = WAIT_VS;
            end
            WAIT_VS: begin
                if (vsync_s2) state_nxt = WAIT_ACT;
            end
            WAIT_ACT: begin
                if (!vsync_s2) begin
                    state_nxt = ACTIVE;
                    clr_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (vsync_rise) begin
                    end_frame = 1'b1;
                    state_nxt = capture_en ? WAIT_ACT : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctl_s1     <= '0;
            ctl_s2     <= '0;
            ctl_s3     <= '0;
            d_s1       <= '0;
            d_s2       <= '0;
            phase      <= 1'b0;
            byte0      <= '0;
            src_col    <= '0;
            src_row    <= '0;
            pix_pend   <= 1'b0;
            pix_data   <= '0;
            done_pend  <= 1'b0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            busy       <= 1'b0;
        end else begin
            ctl_s1 <= {cam_vsync, cam_href, cam_pclk};
            ctl_s2 <= ctl_s1;
            ctl_s3 <= ctl_s2;
            d_s1   <= cam_d;
            d_s2   <= d_s1;

            // One extra register stage on both the pixel and the frame end so that
            // wr_en and frame_done land three clocks after the camera edge is first sampled.
            pix_pend   <= 1'b0;
            done_pend  <= end_frame;
            frame_done <= done_pend;
            busy       <= (state == ACTIVE);
            wr_en      <= pix_pend;
            if (pix_pend) wr_data <= pix_data;

            if (clr_frame) begin
                wr_addr <= '0;
            end else if (wr_en && wr_addr != c_last_addr) begin
                wr_addr <= wr_addr + 1'b1;
            end

            if (clr_frame) begin
                src_col <= '0;
                src_row <= '0;
                phase   <= 1'b0;
            end else if (state == ACTIVE) begin
                if (href_fall) begin
                    src_col <= '0;
                    phase   <= 1'b0;
                    if (src_row != '1) src_row <= src_row + 1'b1;
                end else if (pclk_rise && href_s2) begin
                    if (!phase) begin
                        byte0 <= {d_s2[7:4], d_s2[2:0]};
                        phase <= 1'b1;
                    end else begin
                        phase    <= 1'b0;
                        pix_pend <= keep_pixel;
                        pix_data <= c_nb_buf'({byte0[6:3], byte0[2:0], d_s2[7], d_s2[4:1]});
                        if (src_col != '1) src_col <= src_col + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ov7670_capture.sv
// tb/tb_ov7670_capture.sv - scoreboard bench for ov7670_capture on a 4x2 destination image

module tb_ov7670_capture;

    localparam int COLS = 4;
    localparam int ROWS = 2;
    localparam int NB   = 4;
    localparam int DL   = 3;
    localparam int LAST = COLS * ROWS - 1;
    localparam int SRC_COLS = COLS * 8;
    localparam int SRC_ROWS = ROWS * 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          cam_pclk, cam_vsync, cam_href;
    logic [7:0]    cam_d;
    logic          capture_en;
    logic          wr_en;
    logic [NB-1:0] wr_addr;
    logic [11:0]   wr_data;
    logic          frame_done;
    logic          busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [31:0] sb[$];
    int          rd = 0;
    int          nwr = 0, nfd = 0;
    int          last_wr_cyc = 0, fd_cyc = 0;
    logic        fd_busy = 1'b0;
    logic        prev_wr = 1'b0;
    logic [NB-1:0] prev_addr = '0;
    logic [11:0] mem [0:LAST];
    int          t_vs = 0, t_rise = 0;

    ov7670_capture #(
        .c_img_cols(COLS), .c_img_rows(ROWS), .c_nb_img_pxls(NB),
        .c_decim_log2(DL), .c_nb_buf(12)
    ) dut (
        .clk(clk), .reset(reset), .cam_pclk(cam_pclk), .cam_vsync(cam_vsync),
        .cam_href(cam_href), .cam_d(cam_d), .capture_en(capture_en),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .frame_done(frame_done), .busy(busy)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(20_000_000);
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] pat(input int row, input int col);
        return 16'((row << 11) | col);
    endfunction

    function automatic logic [11:0] exp_rgb(input logic [15:0] p);
        return {p[15:12], p[10:7], p[4:1]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        cam_d    = b;
        cam_pclk = 1'b0;
        repeat (2) @(negedge clk);
        cam_pclk = 1'b1;
        t_rise   = cyc + 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic send_line(input int ncols, input int row, input bit exp_wr, input bit single);
        logic [15:0] p;
        cam_href = 1'b1;
        for (int c = 0; c < ncols; c++) begin
            p = single ? 16'hF81F : pat(row, c);
            if (exp_wr && row % 8 == 0 && c % 8 == 0 && c / 8 < COLS && row / 8 < ROWS)
                sb.push_back({16'((row / 8) * COLS + c / 8), 4'h0, exp_rgb(p)});
            send_byte(p[15:8]);
            send_byte(p[7:0]);
        end
        cam_href = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic send_rows(input int ncols, input int r0, input int r1, input bit exp_wr);
        for (int r = r0; r < r1; r++) send_line(ncols, r, exp_wr, 1'b0);
    endtask

    task automatic vs_pulse();
        cam_vsync = 1'b1;
        t_vs      = cyc + 1;
        repeat (12) @(negedge clk);
        cam_vsync = 1'b0;
        repeat (12) @(negedge clk);
    endtask

    initial begin
        int base_wr, base_fd;
        logic [31:0] e;

        reset = 1'b1; capture_en = 1'b0;
        cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_d = '0;
        repeat (4) @(negedge clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_busy", busy, 0);
        reset = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (frame_done) begin nfd++; fd_cyc = cyc; fd_busy = busy; end
                if (prev_wr) chk("addr_inc", wr_addr, (prev_addr == LAST) ? LAST : prev_addr + 1);
                if (wr_en) begin
                    chk("pulse_width", prev_wr, 0);
                    checks++;
                    assert (rd < sb.size()) else begin
                        failures++;
                        $error("FAIL spurious_wr observed=addr %0d expected=no write", wr_addr);
                    end
                    if (rd < sb.size()) begin
                        e = sb[rd];
                        rd++;
                        chk("wr_addr", wr_addr, e[31:16]);
                        chk("wr_data", wr_data, e[11:0]);
                    end
                    mem[wr_addr] = wr_data;
                    nwr++;
                    last_wr_cyc = cyc;
                end
                prev_wr   = wr_en;
                prev_addr = wr_addr;
            end
        join_none

        // Single pixel, write latency, short frame still ends with frame_done
        capture_en = 1'b1;
        vs_pulse();
        chk("busy_active", busy, 1);
        base_wr = nwr;
        send_line(1, 0, 1'b1, 1'b1);
        chk("single_latency", last_wr_cyc - t_rise, 3);
        chk("single_count", nwr - base_wr, 1);
        base_fd = nfd;
        vs_pulse();
        chk("short_frame_done", nfd - base_fd, 1);
        chk("frame_done_latency", fd_cyc - t_vs, 3);
        chk("busy_falls_with_done", fd_busy, 0);

        // Full gradient frame
        base_wr = nwr; base_fd = nfd;
        send_rows(SRC_COLS, 0, SRC_ROWS, 1'b1);
        vs_pulse();
        chk("full_writes", nwr - base_wr, COLS * ROWS);
        chk("full_done", nfd - base_fd, 1);
        chk("pix_8_8", mem[COLS + 1], exp_rgb(pat(8, 8)));
        chk("full_drained", sb.size() - rd, 0);

        // Reset in the middle of a frame
        send_rows(SRC_COLS, 0, 2, 1'b1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_wr_en", wr_en, 0);
        chk("midrst_wr_addr", wr_addr, 0);
        chk("midrst_wr_data", wr_data, 0);
        chk("midrst_frame_done", frame_done, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_drained", sb.size() - rd, 0);
        base_wr = nwr; base_fd = nfd;
        send_rows(SRC_COLS, 2, SRC_ROWS, 1'b0);
        vs_pulse();
        chk("aborted_no_done", nfd - base_fd, 0);
        chk("aborted_no_wr", nwr - base_wr, 0);
        send_rows(SRC_COLS, 0, SRC_ROWS, 1'b1);
        vs_pulse();
        chk("after_rst_writes", nwr - base_wr, COLS * ROWS);
        chk("after_rst_done", nfd - base_fd, 1);

        // Oversize source frame
        base_wr = nwr; base_fd = nfd;
        send_rows(SRC_COLS + 8, 0, SRC_ROWS + 4, 1'b1);
        chk("oversize_addr_hold", wr_addr, LAST);
        chk("oversize_writes", nwr - base_wr, COLS * ROWS);
        vs_pulse();
        chk("oversize_done", nfd - base_fd, 1);

        // capture_en dropped mid-frame
        base_wr = nwr; base_fd = nfd;
        send_rows(SRC_COLS, 0, 4, 1'b1);
        capture_en = 1'b0;
        send_rows(SRC_COLS, 4, SRC_ROWS, 1'b1);
        vs_pulse();
        chk("drop_writes", nwr - base_wr, COLS * ROWS);
        chk("drop_done", nfd - base_fd, 1);
        chk("drop_idle", busy, 0);
        base_wr = nwr; base_fd = nfd;
        send_rows(SRC_COLS, 0, SRC_ROWS, 1'b0);
        vs_pulse();
        chk("ignored_writes", nwr - base_wr, 0);
        chk("ignored_done", nfd - base_fd, 0);

        // capture_en raised mid-frame
        send_rows(SRC_COLS, 0, 4, 1'b0);
        capture_en = 1'b1;
        send_rows(SRC_COLS, 4, SRC_ROWS, 1'b0);
        chk("late_en_no_wr", nwr - base_wr, 0);
        vs_pulse();
        chk("late_en_no_done", nfd - base_fd, 0);
        send_rows(SRC_COLS, 0, SRC_ROWS, 1'b1);
        vs_pulse();
        chk("late_en_writes", nwr - base_wr, COLS * ROWS);
        chk("late_en_done", nfd - base_fd, 1);
        chk("final_drained", sb.size() - rd, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Receives the OV7670 parallel pixel stream (PCLK/VSYNC/HREF/D[7:0], RGB565 output mode), oversamples it in the 25 MHz system clock domain, decimates the 640x480 source frame to 80x60, and writes RGB444 pixels into the frame buffer that the OLED path reads. It is the writer side of the frame buffer and fills the same 80x60, 12-bit, row-major address space that is scanned out to the display.

## Interface
Parameters:
- c_img_cols, 80, destination columns
- c_img_rows, 60, destination rows
- c_nb_img_pxls, 13, buffer address width (80*60 = 4800 < 2^13)
- c_decim_log2, 3, log2 of the decimation factor in both axes (factor 8)
- c_nb_buf, 12, buffer word width (RGB444)

Ports:
- clk  in  1  system clock, 25 MHz; the only clock
- reset  in  1  synchronous, active-high
- cam_pclk  in  1  camera pixel clock, asynchronous, ≤ 6.25 MHz (≤ clk/4)
- cam_vsync  in  1  camera frame sync, high during vertical blanking
- cam_href  in  1  camera line valid
- cam_d  in  8  camera data byte
- capture_en  in  1  1 = keep capturing frames; 0 = finish current frame, then idle
- wr_en  out  1  buffer write strobe, one cycle per pixel
- wr_addr  out  13  buffer address, row*80+col
- wr_data  out  12  {R[3:0],G[3:0],B[3:0]}
- frame_done  out  1  one-cycle pulse when a frame completes
- busy  out  1  high while in ACTIVE

## Operation
- All four camera inputs pass through an identical 2-FF synchronizer, then a third register for edge detection; a PCLK rising edge is s2 & ~s3. Data, HREF and VSYNC are used from stage s2, aligned with the edge.
- FSM states: IDLE, WAIT_VS (wait for VSYNC high), WAIT_ACT (wait for VSYNC low), ACTIVE.
  - IDLE -> WAIT_VS when capture_en=1.
  - WAIT_VS -> WAIT_ACT on synced VSYNC=1.
  - WAIT_ACT -> ACTIVE on synced VSYNC=0. Clears src_row, src_col, byte phase, wr_addr.
  - ACTIVE -> on synced VSYNC rising: pulse frame_done; go to WAIT_ACT if capture_en=1, else IDLE.
- Capture starts only from a VSYNC high->low transition. A partial frame is never written.
- Byte assembly (ACTIVE, PCLK edge with HREF=1):
  - Phase 0 stores byte0 = {R[4:0],G[5:3]}.
  - Phase 1 forms the pixel with byte1 = {G[2:0],B[4:0]}, then increments src_col (10 bits).
- HREF falling edge (synced): clear src_col and byte phase, increment src_row (9 bits).
- A pixel is written when all of these hold:
  - phase 1 completes,
  - src_col[2:0]==0 and src_row[2:0]==0,
  - src_col>>3 < c_img_cols and src_row>>3 < c_img_rows.
- Write data: wr_data = {R[4:1], G[5:2], B[4:1]}, i.e. the top 4 bits of each channel.
- wr_addr is a running counter: it holds the current write address, increments after each write, and saturates at 4799. Extra source pixels or lines are never written.
- Fewer source lines than expected: frame_done still fires on VSYNC; the unwritten buffer locations keep their old content.
- HREF asserted outside ACTIVE is ignored.

## Timing
- Reset values: wr_en=0, wr_addr=0, wr_data=0, frame_done=0, busy=0, FSM=IDLE, all counters 0, synchronizer stages 0.
- Reset applies mid-frame: next state is IDLE, no further writes, and no frame_done for the aborted frame.
- Latency: if clk edge N is the first edge that samples cam_pclk=1 for a phase-1 byte, wr_en and wr_data are registered at edge N+3 and wr_en stays high exactly 1 cycle.
- wr_addr is valid together with wr_en and increments on the cycle after it.
- frame_done is registered at edge N+3 relative to the first clk sample of VSYNC=1.
- busy rises the cycle after ACTIVE is entered and falls together with frame_done.
- PCLK high and low phases must each be ≥ 2 clk periods. At exactly clk/4, every edge must be captured. Faster PCLK is out of spec.
- capture_en is sampled only at the ACTIVE exit. Deasserting it mid-frame does not truncate the frame.

## Test plan
- Reset mid-frame: run 10 lines of a frame, assert reset 1 cycle → all outputs 0, FSM IDLE, no frame_done, no wr_en until the next full VSYNC high->low.
- Full frame, gradient pattern (pixel value = src_col), PCLK = 6.25 MHz → exactly 4800 wr_en pulses, addresses 0..4799 in order, one frame_done, pixel at wr_addr 81 derived from source (8,8).
- Single pixel check: byte0=0xF8, byte1=0x1F at source (0,0) → wr_data=0xF0F; wr_en at N+3.
- Oversize frame, 700x500 → writes stop at 4800, wr_addr holds 4799, no wraparound to 0.
- capture_en dropped mid-frame → frame completes with 4800 writes, frame_done pulses, FSM returns to IDLE, next frame ignored.
- Enable mid-frame: capture_en raised while VSYNC low and HREF toggling → no writes until VSYNC high then low; the first write is at address 0.
